// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the fetch PC, drives the fetch handshake and inserts a flush bubble on redirects.
// Optional alignment enforcement on redirect targets is compiled in with `define PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_fetch_ready,
    input  logic             i_branch_taken,
    input  logic [31:0]      i_branch_target,
    input  logic             i_jump,
    input  logic [31:0]      i_jump_target,
    output logic [31:0]      o_pc_out,
    output logic [31:0]      o_pc_plus4,
    output logic             o_fetch_valid,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_redirect_cnt,
    output logic             o_misalign_err
);

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_FETCH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_next;
    logic [31:0]      w_pc_plus4;
    logic [CNT_W-1:0] r_cnt;
    logic             w_redirect_req;
    logic             w_accept;
    logic [31:0]      w_target_raw;
    logic [31:0]      w_target;

    // Jump outranks a simultaneous taken branch.
    assign w_redirect_req = i_jump | i_branch_taken;
    assign w_target_raw   = i_jump ? i_jump_target : i_branch_target;
    assign w_accept       = w_redirect_req &&
                            ((r_state == S_FETCH) || (r_state == S_REDIRECT));
    assign w_pc_plus4     = r_pc + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
    logic w_target_misaligned;
    logic r_misalign;

    assign w_target            = {w_target_raw[31:2], 2'b00};
    assign w_target_misaligned = |w_target_raw[1:0];

    // Accepted redirects always land in REDIRECT, so this pulse lines up with the bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept & w_target_misaligned;
        end
    end

    assign o_misalign_err = r_misalign;
`else
    assign w_target       = w_target_raw;
    assign o_misalign_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            S_BOOT: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_redirect_req) begin
                    w_pc_next    = w_target;
                    w_next_state = S_REDIRECT;
                end else if (i_fetch_ready && !i_stall) begin
                    w_pc_next = w_pc_plus4;
                end
            end
            S_REDIRECT: begin
                if (w_redirect_req) begin
                    w_pc_next = w_target;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    // Saturating count of accepted redirects.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_pc_out       = r_pc;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_fetch_valid  = (r_state == S_FETCH);
    assign o_flush        = (r_state == S_REDIRECT);
    assign o_redirect_cnt = r_cnt;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage directly upstream of the branch-target adder. Holds the architectural PC and presents it to instruction memory through a valid/ready fetch handshake. Exports pc_plus4 for the target adder and the IF/ID register. Selects the next PC from sequential, branch-target and jump-target sources, and inserts a one-cycle flush bubble on every redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the saturating redirect counter

Ports:
Clk  input  1  clock, rising-edge
Reset  input  1  asynchronous, active-low reset
stall  input  1  hazard-unit stall; hold PC
fetch_ready  input  1  instruction memory accepts the current fetch
branch_taken  input  1  branch resolved taken this cycle
branch_target  input  32  target from the branch adder
jump  input  1  jump resolved this cycle
jump_target  input  32  jump target address
pc_out  output  32  current fetch address
pc_plus4  output  32  pc_out + 4, combinational
fetch_valid  output  1  pc_out is a valid fetch request
flush  output  1  one-cycle pulse; squash the IF/ID contents
redirect_cnt  output  CNT_W  number of accepted redirects, saturating
misalign_err  output  1  see Optional Feature

Behaviour:
- Reset (Reset=0, asynchronous):
  - pc_out=RESET_PC, fetch_valid=0, flush=0, redirect_cnt=0, misalign_err=0.
  - State goes to BOOT.
- States: BOOT, FETCH, REDIRECT. All state and register updates happen on the rising edge of Clk.
- BOOT:
  - Lasts exactly one cycle after Reset deasserts, with fetch_valid=0.
  - Redirect inputs are ignored.
  - Next state is FETCH.
- FETCH:
  - fetch_valid=1.
  - Priority: jump > branch_taken > sequential.
  - jump=1: pc_out<=jump_target, go to REDIRECT. Applies regardless of stall or fetch_ready.
  - Else branch_taken=1: pc_out<=branch_target, go to REDIRECT. Applies regardless of stall or fetch_ready.
  - Else if fetch_ready=1 and stall=0: pc_out<=pc_out+4.
  - Else: hold pc_out.
- REDIRECT:
  - fetch_valid=0 and flush=1 for the whole cycle.
  - A new jump or branch_taken in this cycle is accepted: pc_out is loaded with the new target, the block stays in REDIRECT one more cycle, and the counter increments.
  - Otherwise go to FETCH; pc_out is held.
- redirect_cnt:
  - Increments by 1 on each accepted redirect.
  - Saturates at all-ones and does not wrap.
- Arithmetic:
  - pc_out+4 is computed modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - pc_plus4 tracks pc_out with zero cycles of latency.
- Simultaneous jump and branch_taken: jump wins, and the counter counts one redirect.
- Reset asserted mid-operation: immediate return to reset values; any pending redirect is discarded.
- Latency from redirect input to the target appearing on pc_out: 1 cycle. The target is fetched with fetch_valid=1 in the cycle after the REDIRECT bubble.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined:
  - An accepted target with bits [1:0] != 2'b00 is loaded with bits [1:0] forced to 00.
  - misalign_err pulses high for one cycle, coincident with that REDIRECT cycle.
  - misalign_err is 0 at all other times.
- Undefined:
  - Targets are loaded verbatim.
  - misalign_err is tied to 0.
  - No alignment logic is synthesized.

Test Plan:
- Reset then release, fetch_ready=1, stall=0 -> one cycle fetch_valid=0 at pc_out=0; then pc_out 0x0, 0x4, 0x8 on successive cycles with fetch_valid=1.
- In FETCH at pc_out=0x10, stall=1 for 3 cycles -> pc_out held at 0x10 for those 3 cycles; advances to 0x14 in the cycle after stall drops.
- branch_taken=1 with branch_target=0x40 at pc_out=0x20 -> next cycle pc_out=0x40, flush=1, fetch_valid=0, redirect_cnt=1; following cycle fetch_valid=1 with pc_out=0x40; then 0x44.
- jump=1 (jump_target=0x100) and branch_taken=1 (branch_target=0x80) in the same cycle, with stall=1 -> pc_out=0x100; redirect_cnt increments by exactly 1.
- Back-to-back redirects: branch to 0x200, then jump to 0x300 during the REDIRECT cycle -> two flush cycles; pc_out=0x300; redirect_cnt +2. Separately, with RESET_PC=32'hFFFF_FFFC and one advance -> pc_out wraps to 0x0.
- With PC_ALIGN_CHECK_EN defined: branch_target=0x46 -> pc_out=0x44 and misalign_err=1 for one cycle. Without the macro: pc_out=0x46 and misalign_err=0. Also assert Reset mid-REDIRECT -> pc_out=RESET_PC, flush=0, redirect_cnt=0.
